// File: rtl/mem_port_arbiter.sv
// Two-channel round-robin arbiter in front of a single-port memory.
// One transaction is in flight at a time, and every output is registered.
module mem_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          req_oe,
   input  logic [1:0]          req_we,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   input  logic [7:0]          req_size,
   output logic [2*DATA_W-1:0] req_rdata,
   output logic [1:0]          req_rdy,
   output logic                mem_oe,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]   mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                err
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ISSUE, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              last_grant;
   logic              gnt_ch;
   logic              gnt_rd;
   logic [DATA_W-1:0] rdata_p0;

   logic [1:0]        elig;
   logic              grant_any;
   logic              grant_ch;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_size;

   // Low `size` bits set; a shift past the top bit leaves all ones.
   function automatic logic [DATA_W-1:0] wmask_f(input logic [3:0] size);
      logic [DATA_W-1:0] ones;
      ones = '1;
      return ~(ones << size);
   endfunction

   // A channel whose completion pulse is showing is still holding its
   // request, so it is masked out to avoid granting it twice.
   always_comb begin
      elig      = (req_oe ^ req_we) & ~req_rdy;
      grant_any = |elig;
      grant_ch  = (elig == 2'b11) ? ~last_grant : elig[1];
      sel_addr  = grant_ch ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
      sel_wdata = grant_ch ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
      sel_size  = grant_ch ? req_size[7:4]               : req_size[3:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         gnt_ch     <= 1'b0;
         gnt_rd     <= 1'b0;
         err        <= 1'b0;
         req_rdy    <= '0;
         req_rdata  <= '0;
         mem_oe     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
      end else begin
         mem_oe    <= 1'b0;
         mem_we    <= 1'b0;
         req_rdy   <= '0;
         req_rdata <= '0;
         case (state)
            IDLE: begin
               if (|(req_oe & req_we))
                  err <= 1'b1;
               if (grant_any) begin
                  gnt_ch     <= grant_ch;
                  last_grant <= grant_ch;
                  mem_addr   <= sel_addr;
                  if (req_oe[grant_ch]) begin
                     gnt_rd <= 1'b1;
                     mem_oe <= 1'b1;
                     cnt    <= CNT_W'(1);
                     state  <= RD_WAIT;
                  end else begin
                     gnt_rd    <= 1'b0;
                     mem_we    <= 1'b1;
                     mem_wdata <= sel_wdata;
                     mem_wmask <= wmask_f(sel_size);
                     state     <= WR_ISSUE;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == CNT_W'(RD_LAT)) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WR_ISSUE: state <= DONE;
            DONE: begin
               req_rdy <= gnt_ch ? 2'b10 : 2'b01;
               if (gnt_rd)
                  req_rdata <= gnt_ch ? {rdata_p0, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, rdata_p0};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data capture stage: holds the memory word until the completion pulse.
   always_ff @(posedge clock) begin
      if (state == RD_WAIT && cnt == CNT_W'(RD_LAT))
         rdata_p0 <= mem_rdata;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drivers push expected completions and
// writes into queues, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_oe = '0;
   logic [1:0]  req_we = '0;
   logic [19:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic [7:0]  req_size = '0;
   logic [15:0] req_rdata;
   logic [1:0]  req_rdy;
   logic        mem_oe, mem_we;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata, mem_wmask;
   logic [7:0]  mem_rdata = '0;
   logic        err;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .reset(reset), .req_oe(req_oe), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_rdata(req_rdata), .req_rdy(req_rdy), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   typedef struct { logic [15:0] rdata; int cyc; } rsp_t;
   typedef struct { logic [9:0] addr; logic [7:0] wdata; logic [7:0] wmask; } wr_t;

   rsp_t q0[$];
   rsp_t q1[$];
   wr_t  wq[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic mem_oe_prev = 1'b0;
   bit   chk_alt = 1'b0;
   int   last_ch = -1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory model (word = addr[7:0] ^ 0xA0, valid from the strobe cycle on) and monitor.
   always @(negedge clock) begin
      rsp_t e;
      wr_t  w;
      int   ch;
      if (mem_oe) mem_rdata = mem_addr[7:0] ^ 8'hA0;
      if (reset) begin
         if (mem_oe || mem_we) chk("strobe_excl", {mem_oe, mem_we} == 2'b11, 0);
         if (mem_oe) chk("oe_one_cycle", mem_oe_prev, 0);
         if (mem_we) begin
            if (wq.size() == 0) chk("unexpected_we", 1, 0);
            else begin
               w = wq.pop_front();
               chk("write_port", {mem_addr, mem_wdata, mem_wmask}, {w.addr, w.wdata, w.wmask});
            end
         end
         if (req_rdy != 2'b00) begin
            chk("rdy_onehot", req_rdy == 2'b11, 0);
            ch = req_rdy[1] ? 1 : 0;
            if (chk_alt) begin
               if (last_ch >= 0) chk("alternate_grant", ch, 1 - last_ch);
               last_ch = ch;
            end
            if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0))
               chk("unexpected_rdy", req_rdy, 0);
            else begin
               e = (ch == 0) ? q0.pop_front() : q1.pop_front();
               chk("rdata", req_rdata, e.rdata);
               if (e.cyc >= 0) chk("latency", cyc, e.cyc);
            end
         end
      end
      mem_oe_prev = mem_oe;
   end

   // One request on a channel, held until the edge that ends its req_rdy cycle.
   task automatic issue(input int ch, input bit rd, input logic [9:0] a, input logic [7:0] wd,
                        input logic [3:0] sz, input logic [7:0] exp_d, input logic [7:0] exp_m,
                        input bit lat_chk);
      rsp_t e;
      wr_t  w;
      int   k;
      @(posedge clock); #1;
      if (ch == 0) begin
         req_oe[0] = rd; req_we[0] = !rd; req_addr[9:0] = a; req_wdata[7:0] = wd; req_size[3:0] = sz;
      end else begin
         req_oe[1] = rd; req_we[1] = !rd; req_addr[19:10] = a; req_wdata[15:8] = wd; req_size[7:4] = sz;
      end
      e.rdata = !rd ? 16'h0000 : ((ch == 1) ? {exp_d, 8'h00} : {8'h00, exp_d});
      e.cyc   = lat_chk ? (cyc + 1 + (rd ? 3 : 2)) : -1;
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
      if (!rd) begin
         w.addr = a; w.wdata = wd; w.wmask = exp_m;
         wq.push_back(w);
      end
      k = 0;
      do begin
         @(negedge clock);
         k++;
      end while (!req_rdy[ch] && k < 60);
      if (!req_rdy[ch]) chk("rdy_timeout", ch, 99);
      @(posedge clock); #1;
      req_oe[ch] = 1'b0;
      req_we[ch] = 1'b0;
   endtask

   logic [9:0] a0 [3] = '{10'h010, 10'h123, 10'h0F0};
   logic [7:0] d0 [3] = '{8'hB0, 8'h83, 8'h50};
   logic [9:0] a1 [3] = '{10'h044, 10'h1AA, 10'h2CC};
   logic [7:0] d1 [3] = '{8'hE4, 8'h0A, 8'h6C};

   initial begin
      #1 reset = 1'b0;
      #2;
      chk("reset_outputs", {req_rdata, req_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_wmask, err}, 0);
      @(negedge clock); reset = 1'b1;

      // Uncontended read and write, then mask boundaries.
      issue(0, 1, 10'h005, 8'h00, 4'd0, 8'hA5, 8'h00, 1);
      issue(1, 0, 10'h3FF, 8'hFF, 4'd4, 8'h00, 8'h0F, 1);
      issue(0, 0, 10'h100, 8'h5A, 4'd0, 8'h00, 8'h00, 1);
      issue(1, 0, 10'h200, 8'hC3, 4'd9, 8'h00, 8'hFF, 1);
      issue(0, 0, 10'h00C, 8'h3C, 4'd1, 8'h00, 8'h01, 1);
      issue(1, 0, 10'h0AB, 8'h77, 4'd7, 8'h00, 8'h7F, 1);
      issue(1, 1, 10'h3FF, 8'h00, 4'd0, 8'h5F, 8'h00, 1);

      // Both channels streaming reads.
      chk_alt = 1'b1;
      last_ch = -1;
      fork
         begin for (int i = 0; i < 3; i++) issue(0, 1, a0[i], 8'h00, 4'd0, d0[i], 8'h00, 0); end
         begin for (int j = 0; j < 3; j++) issue(1, 1, a1[j], 8'h00, 4'd0, d1[j], 8'h00, 0); end
      join
      chk_alt = 1'b0;

      // Channel 0 asserts read and write together while channel 1 reads.
      @(posedge clock); #1;
      req_oe[0] = 1'b1; req_we[0] = 1'b1; req_addr[9:0] = 10'h0AA;
      issue(1, 1, 10'h055, 8'h00, 4'd0, 8'hF5, 8'h00, 1);
      chk("err_set", err, 1);
      repeat (5) @(negedge clock);
      chk("err_sticky", err, 1);
      @(posedge clock); #1;
      req_oe[0] = 1'b0; req_we[0] = 1'b0;
      repeat (3) @(negedge clock);
      chk("err_sticky_after_drop", err, 1);

      // Reset in the middle of a read.
      @(posedge clock); #1;
      req_oe[0] = 1'b1; req_addr[9:0] = 10'h005;
      @(posedge clock);
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      chk("midreset_outputs", {req_rdata, req_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_wmask, err}, 0);
      req_oe[0] = 1'b0;
      @(negedge clock); reset = 1'b1;
      for (int m = 0; m < 6; m++) begin
         @(negedge clock);
         chk("post_reset_quiet", {req_rdy, mem_oe, mem_we}, 0);
      end
      issue(0, 1, 10'h005, 8'h00, 4'd0, 8'hA5, 8'h00, 1);

      repeat (5) @(negedge clock);
      chk("drain", q0.size() + q1.size() + wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: per-channel address width.
REQ-002 Parameter DATA_W, default 8: per-channel data width.
REQ-003 Parameter RD_LAT, default 2, legal >=1: memory read latency in cycles.
REQ-004 clock  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_oe  in  2  per-channel read request, bit i = channel i.
REQ-007 req_we  in  2  per-channel write request.
REQ-008 req_addr  in  2*ADDR_W  channel i in slice [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  in  2*DATA_W  channel i in slice [i*DATA_W +: DATA_W].
REQ-010 req_size  in  8  channel i in slice [i*4 +: 4]: number of valid low-order write bits.
REQ-011 req_rdata  out  2*DATA_W  read return data, channel-sliced.
REQ-012 req_rdy  out  2  one-cycle completion pulse per channel.
REQ-013 mem_oe, mem_we  out  1 each  single-port memory strobes.
REQ-014 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wmask  out  DATA_W.
REQ-015 mem_rdata  in  DATA_W  memory read data.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 FSM states: IDLE, RD_WAIT, WR_ISSUE, DONE; one transaction in flight at a time.
REQ-018 Requester holds oe/we, addr, wdata, size stable from assertion until the edge ending its req_rdy cycle.
REQ-019 IDLE: channel eligible if exactly one of req_oe[i]/req_we[i] high; no eligible channel -> remain IDLE.
REQ-020 Arbitration round-robin: both eligible -> grant channel != last_grant; one eligible -> grant it; last_grant updated on every grant.
REQ-021 Read grant at edge N: mem_oe=1 with mem_addr during cycle after N only (one cycle), state RD_WAIT.
REQ-022 RD_WAIT: counter counts RD_LAT cycles from the edge sampling mem_oe; mem_rdata captured at edge N+RD_LAT; DONE follows.
REQ-023 Write grant at edge N: mem_we=1, mem_addr, mem_wdata, mem_wmask driven for one cycle (WR_ISSUE), then DONE.
REQ-024 mem_wmask = (1<<size)-1 truncated to DATA_W; size >= DATA_W -> all ones; size=0 -> all zeros, handshake still completes.
REQ-025 DONE: req_rdy[granted]=1 exactly one cycle; read -> req_rdata granted slice = captured data; other slice and write DONE -> zeros; next state IDLE.
REQ-026 Requests ignored in RD_WAIT, WR_ISSUE, DONE; losing channel waits with no req_rdy.
REQ-027 Read latency, uncontended: req_oe sampled at edge N -> req_rdy high in cycle after edge N+RD_LAT+1 (RD_LAT=2: N+3).
REQ-028 Write latency, uncontended: req_we sampled at edge N -> req_rdy high in cycle after edge N+2.
REQ-029 req_oe[i] and req_we[i] both high at IDLE sample -> err=1 (sticky), channel i not granted that cycle.
REQ-030 mem_oe and mem_we never simultaneously high; mem strobes low outside RD_WAIT-first-cycle / WR_ISSUE.
REQ-031 All outputs registered; no combinational path from req_* or mem_rdata to outputs.

Reset
REQ-032 reset low -> immediately: state IDLE, counter 0, last_grant=1 (channel 0 wins first tie), err=0, all outputs 0.
REQ-033 Reset mid-transaction -> in-flight transaction dropped, no req_rdy pulse, no memory strobe after reset release until new grant.
REQ-034 First grant possible at first rising edge after reset deasserts.

Verification
REQ-035 Ch0 read addr 0x05, mem returns 0xA5 with RD_LAT=2 -> mem_oe one cycle, req_rdy=2'b01 at N+3, req_rdata[7:0]=0xA5, [15:8]=0.
REQ-036 Ch1 write addr 0x3FF, wdata 0xFF, size 4 -> mem_we one cycle, mem_wmask=0x0F, req_rdy=2'b10 at N+2.
REQ-037 Both channels read continuously -> grants alternate 0,1,0,1; each req_rdy pulse exactly one cycle; never both bits high.
REQ-038 Ch0 req_oe=req_we=1, ch1 read pending -> err=1 and stays 1, ch1 granted, ch0 never gets req_rdy.
REQ-039 reset low during RD_WAIT -> outputs 0 at once; no req_rdy after release; next request served with normal latency.
REQ-040 Size 0 write, size 9 write (DATA_W=8) -> mem_wmask 0x00 and 0xFF respectively, both complete with req_rdy.
